barrel_coord_sched: RTL

- Raster scheduler that sequences the translate CORDIC (cartesian to polar) for the barrel-distortion math path.
- Walks one eye's pixel grid, converts each pixel to centred 12.4 coordinates and issues it on the CORDIC AXI-stream input.
- Caps in-flight requests and keeps a tag FIFO so each polar result leaves re-paired with its pixel x,y.
- Output feeds the rotate/address stage; issue is gated by mem_ready.

---
 rtl/barrel_coord_sched_pkg.sv | 32 +++
 rtl/barrel_coord_sched_if.sv | 41 ++++
 rtl/barrel_coord_sched_tag_fifo.sv | 72 +++++++
 rtl/barrel_coord_sched.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/barrel_coord_sched_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | barrel_pkg: shared types and field layout for barrel_coord_sched       |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
package barrel_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int c_COORD_W     = 12;
    localparam int c_CART_FRAC   = 4;
    localparam int c_POL_FRAC    = 3;
    localparam int c_CART_X_LSB  = 20;
    localparam int c_CART_Y_LSB  = 4;
    localparam int c_POL_W       = 16;
    localparam int c_POL_RAD_LSB = 0;
    localparam int c_POL_PH_LSB  = 16;
    localparam int c_TAG_W       = 2 * c_COORD_W;

    // Coordinates occupy the integer part of a 12.4 field; fractions stay zero.
    function automatic logic [31:0] pack_cart(input logic [c_COORD_W-1:0] x_off,
                                               input logic [c_COORD_W-1:0] y_off);
        return {x_off, {c_CART_FRAC{1'b0}}, y_off, {c_CART_FRAC{1'b0}}};
    endfunction

endpackage
`default_nettype wire

// File: rtl/barrel_coord_sched_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | barrel_coord_sched_if: CORDIC streams and result port of the scheduler |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
interface barrel_coord_sched_if;
    import barrel_pkg::*;

    logic [31:0]          cart_tdata;
    logic                 cart_tvalid;
    logic                 cart_tready;
    logic [31:0]          pol_tdata;
    logic                 pol_tvalid;
    logic                 pol_tready;
    logic [c_COORD_W-1:0] xOut;
    logic [c_COORD_W-1:0] yOut;
    logic [c_POL_W-1:0]   radius;
    logic [c_POL_W-1:0]   phase;
    logic                 addr_vld;
    logic                 addr_ready;

    modport slave (
        output cart_tdata, cart_tvalid,
        input  cart_tready,
        input  pol_tdata, pol_tvalid,
        output pol_tready,
        output xOut, yOut, radius, phase, addr_vld,
        input  addr_ready
    );

    modport master (
        input  cart_tdata, cart_tvalid,
        output cart_tready,
        output pol_tdata, pol_tvalid,
        input  pol_tready,
        input  xOut, yOut, radius, phase, addr_vld,
        output addr_ready
    );

endinterface
`default_nettype wire

// File: rtl/barrel_coord_sched_tag_fifo.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tag_fifo: synchronous FIFO holding pixel tags of in-flight requests    |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module tag_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 24
) (
    input  wire logic                   clk,
    input  wire logic                   reset,
    input  wire logic                   push,
    input  wire logic [W-1:0]           push_data,
    input  wire logic                   pop,
    output logic      [W-1:0]           pop_data,
    output logic      [$clog2(DEPTH):0] count,
    output logic                        full,
    output logic                        empty
);

    localparam int              c_AW      = $clog2(DEPTH);
    localparam logic [c_AW:0]   c_DEPTH   = (c_AW + 1)'(DEPTH);
    localparam logic [c_AW:0]   c_CNT_ONE = (c_AW + 1)'(1);
    localparam logic [c_AW-1:0] c_PTR_ONE = c_AW'(1);

    // Pointers wrap for free only when DEPTH is a power of two.
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("tag_fifo DEPTH must be a power of two >= 2");
    end

    logic [W-1:0]    r_mem [DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW:0]   r_count;
    logic            w_do_push;
    logic            w_do_pop;

    assign full      = (r_count == c_DEPTH);
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign pop_data  = r_mem[r_rd_ptr];
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/barrel_coord_sched.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | barrel_coord_sched: raster walk feeding the translate CORDIC, results  |
// | re-paired with their pixel via a tag FIFO.                 Rev 1.0     |
// +------------------------------------------------------------------------+
module barrel_coord_sched
    import barrel_pkg::*;
#(
    parameter int WIDTH        = 960,
    parameter int HEIGHT       = 1080,
    parameter int X_CENTER     = 479,
    parameter int Y_CENTER     = 540,
    parameter int MAX_INFLIGHT = 16
) (
    input  wire logic            clk,
    input  wire logic            reset,
    input  wire logic            start,
    input  wire logic            mem_ready,
    barrel_coord_sched_if.slave  bus,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 err
);

    localparam logic [c_COORD_W-1:0] c_X_LAST = c_COORD_W'(WIDTH - 1);
    localparam logic [c_COORD_W-1:0] c_Y_LAST = c_COORD_W'(HEIGHT - 1);
    localparam logic [c_COORD_W-1:0] c_X_CTR  = c_COORD_W'(X_CENTER);
    localparam logic [c_COORD_W-1:0] c_Y_CTR  = c_COORD_W'(Y_CENTER);
    localparam logic [c_COORD_W-1:0] c_ONE    = c_COORD_W'(1);

    state_t                          r_state;
    state_t                          w_state_nxt;
    logic [c_COORD_W-1:0]            r_x;
    logic [c_COORD_W-1:0]            r_y;
    logic [c_COORD_W-1:0]            r_xout;
    logic [c_COORD_W-1:0]            r_yout;
    logic [c_POL_W-1:0]              r_radius;
    logic [c_POL_W-1:0]              r_phase;
    logic                            r_addr_vld;
    logic                            r_err;

    logic [c_COORD_W-1:0]            w_x_off;
    logic [c_COORD_W-1:0]            w_y_off;
    logic                            w_issue;
    logic                            w_retire;
    logic                            w_pop;
    logic                            w_stray;
    logic                            w_last_pix;
    logic [c_TAG_W-1:0]              w_tag;
    logic [$clog2(MAX_INFLIGHT):0]   w_count;
    logic                            w_full;
    logic                            w_empty;

    // 12-bit wrap-around subtraction equals the 13-bit signed difference truncated.
    assign w_x_off    = r_x - c_X_CTR;
    assign w_y_off    = r_y - c_Y_CTR;
    assign w_last_pix = (r_x == c_X_LAST) && (r_y == c_Y_LAST);

    assign bus.cart_tvalid = (r_state == ST_RUN) && mem_ready && !w_full;
    assign bus.cart_tdata  = (r_state == ST_RUN) ? pack_cart(w_x_off, w_y_off) : '0;
    assign w_issue         = bus.cart_tvalid && bus.cart_tready;

    assign bus.pol_tready  = reset && (!r_addr_vld || bus.addr_ready);
    assign w_retire        = bus.pol_tvalid && bus.pol_tready;
    assign w_pop           = w_retire && !w_empty;
    assign w_stray         = w_retire && w_empty;

    assign bus.xOut        = r_xout;
    assign bus.yOut        = r_yout;
    assign bus.radius      = r_radius;
    assign bus.phase       = r_phase;
    assign bus.addr_vld    = r_addr_vld;
    assign err             = r_err;

    tag_fifo #(
        .DEPTH (MAX_INFLIGHT),
        .W     (c_TAG_W)
    ) u_tag_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (w_issue),
        .push_data ({r_x, r_y}),
        .pop       (w_pop),
        .pop_data  (w_tag),
        .count     (w_count),
        .full      (w_full),
        .empty     (w_empty)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        frame_done  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (w_issue && w_last_pix) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                busy = 1'b1;
                if ((w_count == '0) && !r_addr_vld) begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: begin
                frame_done  = 1'b1;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_x <= '0;
            r_y <= '0;
        end else if ((r_state == ST_IDLE) && start) begin
            r_x <= '0;
            r_y <= '0;
        end else if (w_issue) begin
            if (r_x == c_X_LAST) begin
                r_x <= '0;
                r_y <= (r_y == c_Y_LAST) ? '0 : r_y + c_ONE;
            end else begin
                r_x <= r_x + c_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_xout     <= '0;
            r_yout     <= '0;
            r_radius   <= '0;
            r_phase    <= '0;
            r_addr_vld <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            if (w_pop) begin
                r_xout     <= w_tag[c_TAG_W-1 -: c_COORD_W];
                r_yout     <= w_tag[c_COORD_W-1:0];
                r_radius   <= bus.pol_tdata[c_POL_RAD_LSB +: c_POL_W];
                r_phase    <= bus.pol_tdata[c_POL_PH_LSB +: c_POL_W];
                r_addr_vld <= 1'b1;
            end else if (bus.addr_ready) begin
                r_addr_vld <= 1'b0;
            end
            // A result with no matching tag is dropped; only the sticky flag records it.
            if (w_stray) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
